// File: rtl/serial_add_eight.sv
// serial_add_eight: bit-serial adder, one bit per clock LSB first; ports clk, rst, start, dIn0, dIn1, cIn, enable -> busy, done, cOut, dOut (+ovf when SERIAL_ADD_OVF_EN is defined)
module serial_add_eight #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dIn0,
  input  logic [WIDTH-1:0] dIn1,
  input  logic             cIn,
  input  logic             enable,
  output logic             busy,
  output logic             done,
  output logic             cOut,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] dOut
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, result;
  logic [CW-1:0] cnt;
  logic carry, s, c_nx, last;
  always_comb begin
    s = sh_a[0] ^ sh_b[0] ^ carry;
    c_nx = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    last = cnt == CW'(WIDTH - 1);
    state_nx = (state == IDLE && start) ? RUN :
               (state == RUN && last)   ? DONE :
               (state == DONE)          ? IDLE : state;
    busy = state == RUN;
    done = state == DONE;
    dOut = result & {WIDTH{enable}};
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
      result <= '0;
      carry <= 1'b0;
      cnt <= '0;
      cOut <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      sh_a <= dIn0;
      sh_b <= dIn1;
      carry <= cIn;
      cnt <= '0;
    end else if (state == RUN) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      carry <= c_nx;
      result <= {s, result[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      if (last) begin
        cOut <= c_nx;
`ifdef SERIAL_ADD_OVF_EN
        // on the MSB step, carry holds the carry into the MSB
        ovf <= carry ^ c_nx;
`endif
      end
    end
  end
endmodule

// File: tb/tb_serial_add_eight.sv
// tb_serial_add_eight: randomized and directed checks of serial_add_eight against an arithmetic reference
module tb_serial_add_eight;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start, cIn, enable;
  logic [W-1:0] dIn0, dIn1, dOut;
  logic busy, done, cOut;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
  logic exp_v = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] exp_s = '0;
  logic exp_c = 1'b0;
  int dones;

  serial_add_eight #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dIn0(dIn0), .dIn1(dIn1), .cIn(cIn),
    .enable(enable), .busy(busy), .done(done), .cOut(cOut),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .dOut(dOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int u, sg;
    u = int'(a) + int'(b) + int'(ci);
    exp_s = u[W-1:0];
    exp_c = u[W];
    sg = int'($signed(a)) + int'($signed(b)) + int'(ci);
`ifdef SERIAL_ADD_OVF_EN
    exp_v = (sg > 127) || (sg < -128);
`else
    if (sg > 1000) $display("unreachable");
`endif
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    dIn0 = a; dIn1 = b; cIn = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dIn0 = W'($urandom); dIn1 = W'($urandom); cIn = 1'($urandom);
  endtask

  task automatic finish_check(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_dout"}, dOut, exp_s & {W{enable}});
    chk({tag, "_cout"}, cOut, exp_c);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, ovf, exp_v);
`endif
    @(negedge clk);
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_hold"}, dOut, exp_s & {W{enable}});
  endtask

  task automatic do_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic en);
    logic prev_c;
    prev_c = exp_c;
    enable = en;
    launch(a, b, ci);
    model(a, b, ci);
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_cout_held"}, cOut, prev_c);
      if (!en) chk({tag, "_gated"}, dOut, 0);
      @(negedge clk);
    end
    finish_check(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cIn = 1'b0; enable = 1'b1; dIn0 = '0; dIn1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dOut, 0);
    chk("rst_cout", cOut, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    do_add("t1", 8'h3C, 8'h05, 1'b0, 1'b1);
    chk("t1_val", dOut, 8'h41);
    do_add("t2a", 8'hFF, 8'h01, 1'b0, 1'b1);
    chk("t2a_val", {cOut, dOut}, 9'h100);
    do_add("t2b", 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("t2b_val", {cOut, dOut}, 9'h100);
    do_add("t3", 8'h12, 8'h34, 1'b0, 1'b0);
    chk("t3_gated_after", dOut, 0);
    enable = 1'b1; #1;
    chk("t3_enabled", dOut, 8'h46);
    for (int i = 0; i < 4; i++) begin
      enable = ~enable; #1;
      chk("t3_en_cout", cOut, exp_c);
      chk("t3_en_dout", dOut, enable ? 8'h46 : 8'h00);
    end
    enable = 1'b1;
    launch(8'h10, 8'h10, 1'b0);
    model(8'h10, 8'h10, 1'b0);
    dones = 0;
    for (int i = 0; i < W; i++) begin
      if (i == 2) begin dIn0 = 8'hAA; dIn1 = 8'h55; start = 1'b1; end
      if (i == 3) start = 1'b0;
      chk("t4_busy", busy, 1);
      if (done) dones++;
      @(negedge clk);
    end
    finish_check("t4");
    chk("t4_val", {cOut, dOut}, 9'h020);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
      chk("t4_idle", busy, 0);
    end
    chk("t4_no_extra_done", dones, 0);
    launch(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_dout", dOut, 0);
    chk("t5_cout", cOut, 0);
    exp_c = 1'b0; exp_s = '0;
`ifdef SERIAL_ADD_OVF_EN
    exp_v = 1'b0;
`endif
    dones = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("t5_quiet", dones, 0);
    do_add("t5b", 8'h01, 8'h01, 1'b0, 1'b1);
    chk("t5b_val", dOut, 8'h02);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dIn0 = 8'h11; dIn1 = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_dout", dOut, 0);
    exp_c = 1'b0; exp_s = '0;
`ifdef SERIAL_ADD_OVF_EN
    exp_v = 1'b0;
    do_add("t6a", 8'h7F, 8'h01, 1'b0, 1'b1);
    chk("t6a_val", {ovf, cOut, dOut}, 10'h080 | 10'h200);
    do_add("t6b", 8'h80, 8'h80, 1'b0, 1'b1);
    chk("t6b_val", {ovf, cOut, dOut}, 10'h300);
    do_add("t6c", 8'h40, 8'h20, 1'b0, 1'b1);
    chk("t6c_ovf", ovf, 0);
`endif
    for (int i = 0; i < 20; i++)
      do_add("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
